fetch_ctrl: RTL and testbench

Front-end fetch sequencer for the CPU core. It owns the program counter and issues in-order instruction requests to the I-cache with a valid/ready handshake. It tracks outstanding requests and buffers responses in a small FIFO that feeds decode with a valid/ready handshake. On a branch/jump redirect it flushes buffered instructions and discards stale in-flight responses before resuming at the new PC.

---
 rtl/fetch_ctrl.sv | 147 ++++++++++++++
 tb/tb_fetch_ctrl.sv | 338 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the PC, issues in-order I-cache requests and buffers
// responses for decode. Redirects flush the queue and drop stale in-flight responses.
//
//   state | meaning
//   RUN   | issuing requests, responses pushed into the fetch queue
//   FLUSH | no requests; responses are stale and counted down in drop_cnt
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 4
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redir_i,
    input  logic [31:0] redir_pc_i,
    output logic        ic_req_valid_o,
    input  logic        ic_req_ready_i,
    output logic [31:0] ic_req_addr_o,
    input  logic        ic_rsp_valid_i,
    input  logic [31:0] ic_rsp_data_i,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] DEPTH_W = DEPTH[CW:0];

    typedef enum logic {RUN, FLUSH} state_t;

    state_t          state_q;
    state_t          state_d;
    logic [31:0]     pc_q;
    logic [CW-1:0]   out_cnt;
    logic [CW-1:0]   drop_cnt;
    logic [CW-1:0]   drop_d;
    logic [CW-1:0]   count;
    logic [CW:0]     inflight;

    logic [AW-1:0]   pf_wr;
    logic [AW-1:0]   pf_rd;
    logic [AW-1:0]   q_wr;
    logic [AW-1:0]   q_rd;
    logic [31:0]     pf_mem     [DEPTH];
    logic [31:0]     q_pc_mem   [DEPTH];
    logic [31:0]     q_inst_mem [DEPTH];

    logic            req_valid;
    logic            req_fire;
    logic            rsp_ok;
    logic            push;
    logic            pop;
    logic            inst_valid;
    logic [1:0]      unused_redir_lsb;

    assign unused_redir_lsb = redir_pc_i[1:0];
    assign inflight = {1'b0, out_cnt} + {1'b0, count};

    always_comb begin
        state_d    = state_q;
        drop_d     = drop_cnt;
        rsp_ok     = ic_rsp_valid_i && (out_cnt != '0);
        inst_valid = (count != '0) && !redir_i;
        pop        = inst_valid && inst_ready_i;
        req_valid  = rst_ni && (state_q == RUN) && !redir_i && (inflight < DEPTH_W);
        req_fire   = req_valid && ic_req_ready_i;
        push       = rsp_ok && (state_q == RUN) && !redir_i;
        if (redir_i) begin
            // the response landing in the redirect cycle is already consumed
            drop_d  = out_cnt - CW'(rsp_ok);
            state_d = (drop_d != '0) ? FLUSH : RUN;
        end else if (state_q == FLUSH) begin
            if (rsp_ok) begin
                drop_d = drop_cnt - CW'(1);
            end
            if (drop_d == '0) begin
                state_d = RUN;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= RUN;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            pc_q     <= RESET_PC;
            out_cnt  <= '0;
            drop_cnt <= '0;
            count    <= '0;
            pf_wr    <= '0;
            pf_rd    <= '0;
            q_wr     <= '0;
            q_rd     <= '0;
        end else begin
            drop_cnt <= drop_d;
            out_cnt  <= out_cnt + CW'(req_fire) - CW'(rsp_ok);
            if (req_fire) begin
                pf_wr <= pf_wr + AW'(1);
            end
            // PC FIFO stays aligned with the cache, stale responses included
            if (rsp_ok) begin
                pf_rd <= pf_rd + AW'(1);
            end
            if (redir_i) begin
                pc_q  <= {redir_pc_i[31:2], 2'b00};
                count <= '0;
                q_wr  <= '0;
                q_rd  <= '0;
            end else begin
                if (req_fire) begin
                    pc_q <= pc_q + 32'd4;
                end
                if (push) begin
                    q_wr <= q_wr + AW'(1);
                end
                if (pop) begin
                    q_rd <= q_rd + AW'(1);
                end
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (req_fire) begin
            pf_mem[pf_wr] <= pc_q;
        end
        if (push) begin
            q_pc_mem[q_wr]   <= pf_mem[pf_rd];
            q_inst_mem[q_wr] <= ic_rsp_data_i;
        end
    end

    assign ic_req_valid_o = req_valid;
    assign ic_req_addr_o  = pc_q;
    assign inst_valid_o   = inst_valid;
    assign inst_o         = (count != '0) ? q_inst_mem[q_rd] : 32'h0;
    assign inst_pc_o      = (count != '0) ? q_pc_mem[q_rd]   : 32'h0;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: an in-order I-cache model feeds a scoreboard of
// expected {pc, instruction} pairs that is checked on every decode pop.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n = 1'b0;
    logic        redir = 1'b0;
    logic [31:0] redir_pc = 32'h0;
    logic        req_valid;
    logic        req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        rsp_valid = 1'b0;
    logic [31:0] rsp_data = 32'h0;
    logic        inst_valid;
    logic        inst_ready = 1'b1;
    logic [31:0] inst;
    logic [31:0] inst_pc;

    logic        w_rst_n = 1'b0;
    logic        w_redir = 1'b0;
    logic [31:0] w_redir_pc = 32'h0;
    logic        w_req_valid;
    logic        w_req_ready = 1'b1;
    logic [31:0] w_req_addr;
    logic        w_rsp_valid = 1'b0;
    logic [31:0] w_rsp_data = 32'h0;
    logic        w_inst_valid;
    logic        w_inst_ready = 1'b1;
    logic [31:0] w_inst;
    logic [31:0] w_inst_pc;

    fetch_ctrl #(.RESET_PC(32'h0000_0000), .DEPTH(4)) dut (
        .clk_i(clk), .rst_ni(rst_n), .redir_i(redir), .redir_pc_i(redir_pc),
        .ic_req_valid_o(req_valid), .ic_req_ready_i(req_ready), .ic_req_addr_o(req_addr),
        .ic_rsp_valid_i(rsp_valid), .ic_rsp_data_i(rsp_data),
        .inst_valid_o(inst_valid), .inst_ready_i(inst_ready), .inst_o(inst), .inst_pc_o(inst_pc)
    );

    fetch_ctrl #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(4)) dut_w (
        .clk_i(clk), .rst_ni(w_rst_n), .redir_i(w_redir), .redir_pc_i(w_redir_pc),
        .ic_req_valid_o(w_req_valid), .ic_req_ready_i(w_req_ready), .ic_req_addr_o(w_req_addr),
        .ic_rsp_valid_i(w_rsp_valid), .ic_rsp_data_i(w_rsp_data),
        .inst_valid_o(w_inst_valid), .inst_ready_i(w_inst_ready), .inst_o(w_inst), .inst_pc_o(w_inst_pc)
    );

    int n_checks = 0;
    int n_fail   = 0;
    int lat      = 1;
    int cyc      = 0;

    typedef struct {logic [31:0] addr; int due; bit stale;} pend_t;
    typedef struct {logic [31:0] pc; logic [31:0] data;} exp_t;
    pend_t pend[$];
    exp_t  exp_q[$];
    pend_t p_cur;
    exp_t  e_cur;

    function automatic logic [31:0] cache_data(input logic [31:0] a);
        return ~a ^ 32'h1234_0000;
    endfunction

    // cache model + scoreboard; drives responses 1 time unit after each edge
    always @(posedge clk) begin
        if (!rst_n) begin
            pend.delete();
            exp_q.delete();
        end else begin
            if (inst_valid && inst_ready) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL decode_unexpected: got pc=%h inst=%h, required no instruction", inst_pc, inst);
                end else begin
                    e_cur = exp_q.pop_front();
                    if (inst_pc !== e_cur.pc || inst !== e_cur.data) begin
                        n_fail++;
                        $display("FAIL decode_data: got pc=%h inst=%h, required pc=%h inst=%h",
                                 inst_pc, inst, e_cur.pc, e_cur.data);
                    end
                end
            end
            if (redir) exp_q.delete();
            if (rsp_valid && pend.size() > 0) begin
                p_cur = pend.pop_front();
                if (!p_cur.stale && !redir) exp_q.push_back('{p_cur.addr, cache_data(p_cur.addr)});
            end
            if (redir) foreach (pend[i]) pend[i].stale = 1'b1;
            if (req_valid && req_ready) pend.push_back('{req_addr, cyc + lat, 1'b0});
        end
        cyc++;
        #1;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            rsp_valid = 1'b1;
            rsp_data  = cache_data(pend[0].addr);
        end else begin
            rsp_valid = 1'b0;
            rsp_data  = 32'h0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // leaves the bench in the first cycle with rst_n high
    task automatic do_reset();
        rst_n = 1'b0;
        redir = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL reset_req_valid: got %b, required 0", req_valid); end
        n_checks++;
        if (req_addr !== 32'h0) begin n_fail++; $display("FAIL reset_req_addr: got %h, required 00000000", req_addr); end
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL reset_inst_valid: got %b, required 0", inst_valid); end
        n_checks++;
        if ({inst, inst_pc} !== 64'h0) begin n_fail++; $display("FAIL reset_inst: got %h/%h, required 0/0", inst, inst_pc); end
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0})
            begin n_fail++; $display("FAIL first_req: got valid=%b addr=%h, required 1/00000000", req_valid, req_addr); end
    endtask

    task automatic test_free_run();
        lat = 1; req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        tick();
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL no_bypass: got inst_valid=%b in cycle 1, required 0", inst_valid); end
        tick();
        for (int i = 0; i < 16; i++) begin
            n_checks++;
            if ({inst_valid, inst_pc} !== {1'b1, 32'(4 * i)})
                begin n_fail++; $display("FAIL free_run_%0d: got valid=%b pc=%h, required 1/%h", i, inst_valid, inst_pc, 32'(4 * i)); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int hs;
        lat = 1; req_ready = 1'b1; inst_ready = 1'b0;
        do_reset();
        hs = 0;
        for (int i = 0; i < 10; i++) begin
            if (req_valid && req_ready) hs++;
            tick();
        end
        n_checks++;
        if (hs != 4) begin n_fail++; $display("FAIL bp_req_count: got %0d requests, required 4", hs); end
        n_checks++;
        if (req_valid !== 1'b0) begin n_fail++; $display("FAIL bp_req_stall: got req_valid=%b, required 0", req_valid); end
        n_checks++;
        if ({inst_valid, inst_pc} !== {1'b1, 32'h0})
            begin n_fail++; $display("FAIL bp_head: got valid=%b pc=%h, required 1/00000000", inst_valid, inst_pc); end
        inst_ready = 1'b1;
        tick();
        inst_ready = 1'b0;
        hs = 0;
        for (int i = 0; i < 6; i++) begin
            if (req_valid && req_ready) hs++;
            tick();
        end
        n_checks++;
        if (hs != 1) begin n_fail++; $display("FAIL bp_release: got %0d requests after one pop, required 1", hs); end
        inst_ready = 1'b1;
    endtask

    task automatic test_redirect();
        bit found;
        lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        tick();
        tick();
        redir = 1'b1; redir_pc = 32'h0000_0100;
        #1;
        n_checks++;
        if ({req_valid, inst_valid} !== 2'b00)
            begin n_fail++; $display("FAIL redir_cycle: got req_valid=%b inst_valid=%b, required 0/0", req_valid, inst_valid); end
        tick();
        redir = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            n_checks++;
            if ({req_valid, inst_valid} !== 2'b00)
                begin n_fail++; $display("FAIL redir_flush_%0d: got req_valid=%b inst_valid=%b, required 0/0", k, req_valid, inst_valid); end
            tick();
        end
        n_checks++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0000_0100})
            begin n_fail++; $display("FAIL redir_resume: got valid=%b addr=%h, required 1/00000100", req_valid, req_addr); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (inst_valid) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || inst_pc !== 32'h0000_0100)
            begin n_fail++; $display("FAIL redir_first_pc: got found=%b pc=%h, required 1/00000100", found, inst_pc); end
        repeat (6) tick();
    endtask

    task automatic test_redir_rsp_pop(input int lat_v);
        bit          found;
        logic [31:0] tgt;
        tgt = 32'h0000_0040 + 32'(lat_v * 32'h100);
        lat = lat_v; req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        repeat (8) tick();
        n_checks++;
        if ({rsp_valid, inst_valid} !== 2'b11)
            begin n_fail++; $display("FAIL rrp_pre_l%0d: got rsp_valid=%b inst_valid=%b, required 1/1", lat_v, rsp_valid, inst_valid); end
        redir = 1'b1; redir_pc = tgt | 32'h3;
        #1;
        n_checks++;
        if (inst_valid !== 1'b0) begin n_fail++; $display("FAIL rrp_pop_void_l%0d: got inst_valid=%b, required 0", lat_v, inst_valid); end
        tick();
        redir = 1'b0;
        #1;
        for (int k = 1; k < lat_v; k++) begin
            n_checks++;
            if ({req_valid, inst_valid} !== 2'b00)
                begin n_fail++; $display("FAIL rrp_drop_l%0d: got req_valid=%b inst_valid=%b, required 0/0", lat_v, req_valid, inst_valid); end
            tick();
        end
        n_checks++;
        if ({inst_valid, req_valid, req_addr} !== {1'b0, 1'b1, tgt})
            begin n_fail++; $display("FAIL rrp_resume_l%0d: got inst_valid=%b req_valid=%b addr=%h, required 0/1/%h",
                                     lat_v, inst_valid, req_valid, req_addr, tgt); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (inst_valid) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || inst_pc !== tgt)
            begin n_fail++; $display("FAIL rrp_first_pc_l%0d: got found=%b pc=%h, required 1/%h", lat_v, found, inst_pc, tgt); end
        repeat (6) tick();
    endtask

    task automatic test_pc_wrap();
        logic [31:0] exp_addr [3];
        logic        prev_hs;
        logic [31:0] prev_addr;
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        w_rst_n = 1'b0; w_req_ready = 1'b1; w_inst_ready = 1'b1; w_rsp_valid = 1'b0;
        tick();
        tick();
        w_rst_n = 1'b1;
        prev_hs = 1'b0; prev_addr = 32'h0;
        for (int i = 0; i < 3; i++) begin
            w_rsp_valid = prev_hs;
            w_rsp_data  = cache_data(prev_addr);
            #1;
            n_checks++;
            if ({w_req_valid, w_req_addr} !== {1'b1, exp_addr[i]})
                begin n_fail++; $display("FAIL wrap_addr_%0d: got valid=%b addr=%h, required 1/%h", i, w_req_valid, w_req_addr, exp_addr[i]); end
            prev_hs   = w_req_valid && w_req_ready;
            prev_addr = w_req_addr;
            tick();
        end
        w_rsp_valid = prev_hs;
        w_rsp_data  = cache_data(prev_addr);
        w_redir = 1'b1; w_redir_pc = 32'h0000_0203;
        #1;
        n_checks++;
        if (w_req_valid !== 1'b0) begin n_fail++; $display("FAIL wrap_redir_cycle: got req_valid=%b, required 0", w_req_valid); end
        tick();
        w_redir = 1'b0; w_rsp_valid = 1'b0;
        #1;
        n_checks++;
        if ({w_req_valid, w_req_addr} !== {1'b1, 32'h0000_0200})
            begin n_fail++; $display("FAIL wrap_redir_addr: got valid=%b addr=%h, required 1/00000200", w_req_valid, w_req_addr); end
        w_rst_n = 1'b0;
    endtask

    task automatic test_reset_mid();
        bit found;
        lat = 3; req_ready = 1'b1; inst_ready = 1'b1;
        do_reset();
        repeat (6) tick();
        rst_n = 1'b0;
        tick();
        n_checks++;
        if ({req_valid, inst_valid, req_addr, inst, inst_pc} !== {2'b00, 96'h0})
            begin n_fail++; $display("FAIL mid_reset_outputs: got req_valid=%b inst_valid=%b addr=%h inst=%h pc=%h, required all 0",
                                     req_valid, inst_valid, req_addr, inst, inst_pc); end
        tick();
        rst_n = 1'b1;
        #1;
        n_checks++;
        if ({req_valid, req_addr} !== {1'b1, 32'h0})
            begin n_fail++; $display("FAIL mid_reset_restart: got valid=%b addr=%h, required 1/00000000", req_valid, req_addr); end
        found = 1'b0;
        for (int k = 0; k < 20 && !found; k++) begin
            if (inst_valid) found = 1'b1;
            else tick();
        end
        n_checks++;
        if (!found || inst_pc !== 32'h0)
            begin n_fail++; $display("FAIL mid_reset_first_pc: got found=%b pc=%h, required 1/00000000", found, inst_pc); end
        repeat (10) tick();
    endtask

    initial begin
        test_reset();
        test_free_run();
        test_backpressure();
        test_redirect();
        test_redir_rsp_pop(1);
        test_redir_rsp_pop(2);
        test_pc_wrap();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "timeout");
    end

endmodule
